// File: rtl/serial_deserializer_d_pkg.sv
// Shared constants and helpers for the serial deserializer slice.
package serial_deserializer_d_pkg;

  localparam int DEFAULT_WIDTH = 8;

  // Counter width for a WIDTH-bit word; never narrower than one bit.
  function automatic int cnt_width(input int width);
    int w;
    w = $clog2(width);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/serial_deserializer_d_shift.sv
// Chain of D flip-flops with enable and synchronous clear; clear and shift may
// coincide, in which case the incoming bit enters an all-zero register.
module serial_shift_register
  import serial_deserializer_d_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             clear,
  input  logic             shift_en,
  input  logic             d_in,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] base;
  logic [WIDTH-1:0] d_next;

  assign base = clear ? '0 : q;

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_stage
      logic src;
      if (MSB_FIRST) begin : g_msb
        if (i == 0) begin : g_head
          assign src = d_in;
        end else begin : g_link
          assign src = base[i-1];
        end
      end else begin : g_lsb
        if (i == WIDTH - 1) begin : g_head
          assign src = d_in;
        end else begin : g_link
          assign src = base[i+1];
        end
      end
      assign d_next[i] = shift_en ? src : base[i];

      always_ff @(posedge clk) begin
        if (!reset_L) q[i] <= 1'b0;
        else          q[i] <= d_next[i];
      end
    end
  endgenerate

endmodule

// File: rtl/serial_deserializer_d.sv
// Serial-to-parallel deserializer with a one-word holding register, valid/ready
// output handshake, sticky overrun flag and word-boundary realignment.
module serial_deserializer_d
  import serial_deserializer_d_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                        clk,
  input  logic                        reset_L,
  input  logic                        serial_in,
  input  logic                        serial_valid,
  input  logic                        align,
  input  logic                        out_ready,
  input  logic                        overrun_clr,
  output logic [WIDTH-1:0]            data_out,
  output logic                        data_valid,
  output logic [cnt_width(WIDTH)-1:0] bit_count,
  output logic                        overrun
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] word;
  logic             complete;
  logic             xfer;
  logic             hold_free;

  serial_shift_register #(
    .WIDTH    (WIDTH),
    .MSB_FIRST(MSB_FIRST)
  ) u_shift (
    .clk     (clk),
    .reset_L (reset_L),
    .clear   (align),
    .shift_en(serial_valid),
    .d_in    (serial_in),
    .q       (shift_q)
  );

  // The completed word is the value the shift register takes at this edge.
  generate
    if (MSB_FIRST) begin : g_word_msb
      assign word = {shift_q[WIDTH-2:0], serial_in};
    end else begin : g_word_lsb
      assign word = {serial_in, shift_q[WIDTH-1:1]};
    end
  endgenerate

  // Align takes precedence over a completion on the same edge.
  assign complete  = serial_valid && !align && (bit_count == LAST);
  assign xfer      = data_valid && out_ready;
  assign hold_free = !data_valid || xfer;

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      bit_count <= '0;
    end else if (align) begin
      bit_count <= serial_valid ? CW'(1) : '0;
    end else if (serial_valid) begin
      bit_count <= complete ? '0 : bit_count + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      data_out   <= '0;
      data_valid <= 1'b0;
    end else if (complete && hold_free) begin
      data_out   <= word;
      data_valid <= 1'b1;
    end else if (xfer) begin
      data_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_L)                      overrun <= 1'b0;
    else if (complete && !hold_free)   overrun <= 1'b1;
    else if (overrun_clr)              overrun <= 1'b0;
  end

endmodule

// File: tb/tb_serial_deserializer_d.sv
// Scoreboard bench: an MSB-first and an LSB-first instance share the serial
// stream; expected words are queued at stimulus time and popped on transfer.
module tb_serial_deserializer_d;

  logic       clk = 1'b0;
  logic       reset_L = 1'b0;
  logic       serial_in = 1'b0;
  logic       serial_valid = 1'b0;
  logic       align = 1'b0;
  logic       out_ready = 1'b1;
  logic       ready_lsb = 1'b1;
  logic       overrun_clr = 1'b0;

  logic [7:0] data_out_m, data_out_l;
  logic       data_valid_m, data_valid_l;
  logic [2:0] bit_count_m, bit_count_l;
  logic       overrun_m, overrun_l;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] q_m[$];
  logic [7:0] q_l[$];

  always #5 clk = ~clk;

  serial_deserializer_d #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .reset_L(reset_L), .serial_in(serial_in), .serial_valid(serial_valid),
    .align(align), .out_ready(out_ready), .overrun_clr(overrun_clr),
    .data_out(data_out_m), .data_valid(data_valid_m), .bit_count(bit_count_m),
    .overrun(overrun_m)
  );

  serial_deserializer_d #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .reset_L(reset_L), .serial_in(serial_in), .serial_valid(serial_valid),
    .align(align), .out_ready(ready_lsb), .overrun_clr(overrun_clr),
    .data_out(data_out_l), .data_valid(data_valid_l), .bit_count(bit_count_l),
    .overrun(overrun_l)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] w);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = w[7-i];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    serial_valid = 1'b1;
    serial_in    = b;
    tick();
    serial_valid = 1'b0;
  endtask

  // Sends w MSB first; the LSB-first instance therefore assembles rev8(w).
  task automatic send_word(input logic [7:0] w, input bit expect_m);
    if (expect_m) q_m.push_back(w);
    q_l.push_back(rev8(w));
    for (int i = 7; i >= 0; i--) send_bit(w[i]);
  endtask

  // Monitors: a transfer happens at the next rising edge.
  always @(negedge clk) begin
    if (reset_L && data_valid_m && out_ready) begin
      if (q_m.size() == 0) chk("msb_unexpected_word", {24'd0, data_out_m}, 32'hFFFF_FFFF);
      else                 chk("msb_word", {24'd0, data_out_m}, {24'd0, q_m.pop_front()});
    end
    if (reset_L && data_valid_l && ready_lsb) begin
      if (q_l.size() == 0) chk("lsb_unexpected_word", {24'd0, data_out_l}, 32'hFFFF_FFFF);
      else                 chk("lsb_word", {24'd0, data_out_l}, {24'd0, q_l.pop_front()});
    end
  end

  initial begin
    logic [7:0] w;
    // Reset
    tick(); tick();
    chk("rst_data_out", {24'd0, data_out_m}, 32'd0);
    chk("rst_data_valid", {31'd0, data_valid_m}, 32'd0);
    chk("rst_bit_count", {29'd0, bit_count_m}, 32'd0);
    chk("rst_overrun", {31'd0, overrun_m}, 32'd0);
    chk("rst_lsb_valid", {31'd0, data_valid_l}, 32'd0);
    reset_L = 1'b1;

    // Sequential load, both bit orders
    send_word(8'hC0, 1'b1);
    chk("load_data_out", {24'd0, data_out_m}, 32'hC0);
    chk("load_valid", {31'd0, data_valid_m}, 32'd1);
    chk("load_bit_count", {29'd0, bit_count_m}, 32'd0);
    chk("lsb_data_out", {24'd0, data_out_l}, 32'h03);
    tick();
    chk("load_valid_drop", {31'd0, data_valid_m}, 32'd0);

    // Gaps in serial_valid
    w = 8'hC0;
    q_m.push_back(w);
    q_l.push_back(rev8(w));
    for (int i = 7; i >= 4; i--) send_bit(w[i]);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("gap_bit_count", {29'd0, bit_count_m}, 32'd4);
    end
    for (int i = 3; i >= 0; i--) send_bit(w[i]);
    chk("gap_data_out", {24'd0, data_out_m}, 32'hC0);
    tick();

    // Backpressure and overrun
    out_ready = 1'b0;
    send_word(8'hA5, 1'b1);
    chk("bp_valid", {31'd0, data_valid_m}, 32'd1);
    send_word(8'h3C, 1'b0);
    chk("bp_hold_data", {24'd0, data_out_m}, 32'hA5);
    chk("bp_hold_valid", {31'd0, data_valid_m}, 32'd1);
    chk("bp_overrun", {31'd0, overrun_m}, 32'd1);
    chk("lsb_no_overrun", {31'd0, overrun_l}, 32'd0);
    out_ready = 1'b1;
    tick();
    chk("bp_after_xfer_valid", {31'd0, data_valid_m}, 32'd0);
    chk("bp_overrun_sticky", {31'd0, overrun_m}, 32'd1);
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    chk("overrun_clr", {31'd0, overrun_m}, 32'd0);

    // Accept on the same edge as the next completion
    out_ready = 1'b0;
    send_word(8'hA5, 1'b1);
    w = 8'h3C;
    q_m.push_back(w);
    q_l.push_back(rev8(w));
    for (int i = 7; i >= 1; i--) send_bit(w[i]);
    out_ready = 1'b1;
    send_bit(w[0]);
    chk("simul_data_out", {24'd0, data_out_m}, 32'h3C);
    chk("simul_valid", {31'd0, data_valid_m}, 32'd1);
    chk("simul_overrun", {31'd0, overrun_m}, 32'd0);
    tick();

    // Align with serial_valid low
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    align = 1'b1;
    tick();
    align = 1'b0;
    chk("align_bit_count", {29'd0, bit_count_m}, 32'd0);
    send_word(8'hFF, 1'b1);
    chk("align_data_out", {24'd0, data_out_m}, 32'hFF);
    tick();

    // Align on a completion edge: no word, incoming bit starts the next word
    for (int i = 0; i < 7; i++) send_bit(1'b0);
    q_m.push_back(8'hA5);
    q_l.push_back(rev8(8'hA5));
    align = 1'b1;
    send_bit(1'b1);
    align = 1'b0;
    chk("align_cmpl_valid", {31'd0, data_valid_m}, 32'd0);
    chk("align_cmpl_count", {29'd0, bit_count_m}, 32'd1);
    w = 8'hA5;
    for (int i = 6; i >= 0; i--) send_bit(w[i]);
    chk("align_cmpl_word", {24'd0, data_out_m}, 32'hA5);
    tick();

    // Reset mid-word
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    chk("mid_bit_count", {29'd0, bit_count_m}, 32'd5);
    reset_L = 1'b0;
    tick();
    reset_L = 1'b1;
    chk("mid_rst_count", {29'd0, bit_count_m}, 32'd0);
    chk("mid_rst_valid", {31'd0, data_valid_m}, 32'd0);
    tick(); tick();

    chk("msb_queue_empty", q_m.size(), 32'd0);
    chk("lsb_queue_empty", q_l.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
